// File: rtl/nes_pkg.sv
// Shared constants and state type for the NES controller device and console-side interface.
package nes_pkg;

    localparam int unsigned NUM_BUTTONS = 8;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        EMPTY
    } dev_state_e;

endpackage

// File: rtl/nes_controller_device_if.sv
// Console-side pad lines: latch and shift clock from the console, active-low data back.
interface nes_controller_device_if;

    logic console_latch;
    logic console_clk;
    logic serial_n;

    modport master (
        output console_latch,
        output console_clk,
        input  serial_n
    );

    modport slave (
        input  console_latch,
        input  console_clk,
        output serial_n
    );

endinterface

// File: rtl/nes_sync_edge.sv
// Multi-flop synchronizer for an asynchronous console line, with rise/fall pulse detection.
module nes_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~dly_q;
    assign fall_o  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/nes_controller_device.sv
// NES pad responder: shifts 8 button bits onto the console's active-low serial line.
// Optional A/B turbo is enabled with `define NES_DEVICE_TURBO_EN.
module nes_controller_device
    import nes_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TURBO_POLLS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] buttons_i,
    nes_controller_device_if.slave console,
    output logic                   poll_o,
    output logic                   done_o,
    output logic [3:0]             bit_cnt_o
`ifdef NES_DEVICE_TURBO_EN
    ,
    input  logic [1:0]             turbo_en_i
`endif
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TURBO_POLLS < 1) begin : g_bad_cfg
        $error("nes_controller_device: illegal SYNC_STAGES or TURBO_POLLS");
    end

    logic lat_s, lat_rise, lat_fall;
    logic ck_s, ck_rise, ck_fall;

    nes_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latch (
        .clk    (clk),
        .rst    (rst),
        .d_i    (console.console_latch),
        .level_o(lat_s),
        .rise_o (lat_rise),
        .fall_o (lat_fall)
    );

    nes_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk    (clk),
        .rst    (rst),
        .d_i    (console.console_clk),
        .level_o(ck_s),
        .rise_o (ck_rise),
        .fall_o (ck_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{lat_rise, ck_s, ck_fall};

    dev_state_e             state_q, state_d;
    logic [NUM_BUTTONS-1:0] shreg_q, shreg_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   serial_q, serial_d;
    logic                   done;
    logic [NUM_BUTTONS-1:0] eff;

`ifdef NES_DEVICE_TURBO_EN
    localparam int unsigned PollW = (TURBO_POLLS > 1) ? $clog2(TURBO_POLLS) : 1;

    logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        poll_cnt_d = poll_cnt_q;
        phase_d    = phase_q;
        if (lat_fall) begin
            if (poll_cnt_q == PollW'(TURBO_POLLS - 1)) begin
                poll_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                poll_cnt_d = poll_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            phase_q    <= phase_d;
        end
    end

    // Phase 0 masks the turbo button so the first polls after reset read released.
    always_comb begin
        eff        = buttons_i;
        eff[BTN_A] = buttons_i[BTN_A] & (~turbo_en_i[0] | phase_q);
        eff[BTN_B] = buttons_i[BTN_B] & (~turbo_en_i[1] | phase_q);
    end
`else
    assign eff = buttons_i;
`endif

    // A held latch overrides everything, including a same-cycle clock rise.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (lat_s) begin
            state_d = LOAD;
            shreg_d = eff;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (lat_fall) state_d = SHIFT;
                end
                SHIFT: begin
                    if (ck_rise) begin
                        shreg_d = {1'b1, shreg_q[NUM_BUTTONS-1:1]};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            state_d = EMPTY;
                            done    = 1'b1;
                        end
                    end
                end
                EMPTY: ;
                default: state_d = LOAD;
            endcase
        end
        serial_d = (state_d == EMPTY) ? 1'b0 : ~shreg_d[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            shreg_q  <= '0;
            cnt_q    <= 4'd0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
        end
    end

    assign console.serial_n = serial_q;
    assign poll_o           = lat_fall;
    assign done_o           = done;
    assign bit_cnt_o        = cnt_q;

endmodule

// File: tb/tb_nes_controller_device.sv
// Self-checking bench for nes_controller_device acting as a console with a scoreboard of polls.
module tb_nes_controller_device;

    localparam int H = 6;  // console half-period in clk cycles

    logic       clk;
    logic       rst;
    logic [7:0] buttons;
    logic       poll;
    logic       done;
    logic [3:0] bit_cnt;
`ifdef NES_DEVICE_TURBO_EN
    logic [1:0] turbo_en;
`endif

    nes_controller_device_if con_if ();

    nes_controller_device #(
        .SYNC_STAGES(2),
        .TURBO_POLLS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .buttons_i(buttons),
        .console  (con_if.slave),
        .poll_o   (poll),
        .done_o   (done),
        .bit_cnt_o(bit_cnt)
`ifdef NES_DEVICE_TURBO_EN
        ,
        .turbo_en_i(turbo_en)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int poll_seen = 0;
    int done_seen = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (poll) poll_seen++;
        if (done) done_seen++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch_pulse();
        con_if.console_latch = 1'b1;
        wait_cyc(H);
        con_if.console_latch = 1'b0;
        wait_cyc(H);
    endtask

    task automatic ck_pulse();
        con_if.console_clk = 1'b1;
        wait_cyc(H);
        con_if.console_clk = 1'b0;
        wait_cyc(H);
    endtask

    task automatic read_poll(output logic [7:0] data);
        latch_pulse();
        data[0] = ~con_if.serial_n;
        for (int i = 1; i < 8; i++) begin
            ck_pulse();
            data[i] = ~con_if.serial_n;
        end
        ck_pulse();
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst = 1'b1;
        buttons = 8'h00;
        con_if.console_latch = 1'b0;
        con_if.console_clk = 1'b0;
`ifdef NES_DEVICE_TURBO_EN
        turbo_en = 2'b00;
`endif
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(2);
        n_checks++;
        if (con_if.serial_n !== 1'b1) begin
            n_fail++; $display("FAIL reset_serial: got %b want 1", con_if.serial_n);
        end
        n_checks++;
        if (poll !== 1'b0) begin n_fail++; $display("FAIL reset_poll: got %b want 0", poll); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++;
        if (bit_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_bitcnt: got %0d want 0", bit_cnt);
        end
        // Clocks without a latch must not shift anything.
        ck_pulse();
        n_checks++;
        if (bit_cnt !== 4'd0) begin
            n_fail++; $display("FAIL idle_ck_bitcnt: got %0d want 0", bit_cnt);
        end
        got = 8'h00;
    endtask

    task automatic test_sweep();
        logic [7:0] got, exp;
        int p0, d0;
        p0 = poll_seen;
        d0 = done_seen;
        for (int b = 0; b < 256; b++) begin
            buttons = 8'(b);
            exp_q.push_back(8'(b));
            read_poll(got);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL sweep_data: got %h want %h", got, exp);
            end
        end
        n_checks++;
        if (poll_seen - p0 !== 256) begin
            n_fail++; $display("FAIL sweep_polls: got %0d want 256", poll_seen - p0);
        end
        n_checks++;
        if (done_seen - d0 !== 256) begin
            n_fail++; $display("FAIL sweep_dones: got %0d want 256", done_seen - d0);
        end
    endtask

    task automatic test_serial_a();
        int d0;
        logic [7:0] exp_bits;
        exp_bits = 8'b1111_1110;  // serial_n before each ck: 0 then seven 1s
        buttons = 8'h01;
        d0 = done_seen;
        latch_pulse();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (con_if.serial_n !== exp_bits[i]) begin
                n_fail++; $display("FAIL serial_a_bit%0d: got %b want %b", i, con_if.serial_n,
                                   exp_bits[i]);
            end
            ck_pulse();
        end
        n_checks++;
        if (con_if.serial_n !== 1'b0) begin
            n_fail++; $display("FAIL serial_a_empty: got %b want 0", con_if.serial_n);
        end
        n_checks++;
        if (done_seen - d0 !== 1) begin
            n_fail++; $display("FAIL serial_a_done: got %0d want 1", done_seen - d0);
        end
        n_checks++;
        if (bit_cnt !== 4'd8) begin
            n_fail++; $display("FAIL serial_a_bitcnt: got %0d want 8", bit_cnt);
        end
        ck_pulse();
        n_checks++;
        if (bit_cnt !== 4'd8 || con_if.serial_n !== 1'b0 || done_seen - d0 !== 1) begin
            n_fail++; $display("FAIL serial_a_extra_ck: cnt %0d ser %b dones %0d want 8 0 1",
                               bit_cnt, con_if.serial_n, done_seen - d0);
        end
    endtask

    task automatic test_relatch();
        logic [7:0] got, exp;
        int d0;
        buttons = 8'hA5;
        d0 = done_seen;
        latch_pulse();
        repeat (3) ck_pulse();
        n_checks++;
        if (bit_cnt !== 4'd3) begin
            n_fail++; $display("FAIL relatch_mid_cnt: got %0d want 3", bit_cnt);
        end
        buttons = 8'h5A;
        con_if.console_latch = 1'b1;
        wait_cyc(H);
        n_checks++;
        if (bit_cnt !== 4'd0) begin
            n_fail++; $display("FAIL relatch_cnt: got %0d want 0", bit_cnt);
        end
        con_if.console_latch = 1'b0;
        wait_cyc(H);
        n_checks++;
        if (done_seen - d0 !== 0) begin
            n_fail++; $display("FAIL relatch_done: got %0d want 0", done_seen - d0);
        end
        exp_q.push_back(8'h5A);
        read_poll(got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL relatch_data: got %h want %h", got, exp);
        end
    endtask

    task automatic test_simultaneous();
        buttons = 8'hFE;  // A released, B pressed
        con_if.console_latch = 1'b1;
        con_if.console_clk = 1'b1;
        wait_cyc(H);
        con_if.console_latch = 1'b0;
        wait_cyc(H);
        n_checks++;
        if (bit_cnt !== 4'd0) begin
            n_fail++; $display("FAIL simul_cnt: got %0d want 0", bit_cnt);
        end
        n_checks++;
        if (con_if.serial_n !== 1'b1) begin
            n_fail++; $display("FAIL simul_first_bit: got %b want 1", con_if.serial_n);
        end
        con_if.console_clk = 1'b0;
        wait_cyc(H);
        ck_pulse();
        n_checks++;
        if (con_if.serial_n !== 1'b0 || bit_cnt !== 4'd1) begin
            n_fail++; $display("FAIL simul_second_bit: ser %b cnt %0d want 0 1",
                               con_if.serial_n, bit_cnt);
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] got, exp;
        buttons = 8'hF0;
        latch_pulse();
        repeat (4) ck_pulse();
        n_checks++;
        if (bit_cnt !== 4'd4 || con_if.serial_n !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pre: cnt %0d ser %b want 4 0", bit_cnt,
                               con_if.serial_n);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (con_if.serial_n !== 1'b1 || bit_cnt !== 4'd0) begin
            n_fail++; $display("FAIL rstmid_post: ser %b cnt %0d want 1 0", con_if.serial_n,
                               bit_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(2);
        buttons = 8'hFF;
        exp_q.push_back(8'hFF);
        read_poll(got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL rstmid_data: got %h want %h", got, exp);
        end
    endtask

`ifdef NES_DEVICE_TURBO_EN
    task automatic test_turbo();
        logic [7:0] got, exp;
        logic [7:0] a_pattern;
        a_pattern = 8'b1100_1100;  // poll k reads a_pattern[k]
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
        buttons = 8'h01;
        turbo_en = 2'b01;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({7'd0, a_pattern[k]});
            read_poll(got);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL turbo_poll%0d: got %h want %h", k, got, exp);
            end
        end
        turbo_en = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_serial_a();
        test_relatch();
        test_simultaneous();
        test_rst_mid();
`ifdef NES_DEVICE_TURBO_EN
        test_turbo();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
